// File: rtl/sr_cond_pkg.sv
`default_nettype none
// ============================================================================
// sr_cond_pkg -- shared types and defaults for the SR input conditioner.
// Revision: 1.0
// ============================================================================
package sr_cond_pkg;

   localparam int DB_CYCLES_DEF = 4;
   localparam int CNT_W_DEF     = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PULSE_S = 2'd1,
      ST_PULSE_R = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/sr_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// sr_input_conditioner_if -- raw request inputs and conditioned pulse outputs.
// Revision: 1.0
// ============================================================================
interface sr_input_conditioner_if
   import sr_cond_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
);
   logic             set_raw;
   logic             clr_raw;
   logic             s;
   logic             r;
   logic             conflict;
   logic [CNT_W-1:0] conflict_count;

   modport master (
      output set_raw, clr_raw,
      input  s, r, conflict, conflict_count
   );

   modport slave (
      input  set_raw, clr_raw,
      output s, r, conflict, conflict_count
   );
endinterface
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
// sr_debounce -- two-flop synchroniser, counter debounce, registered rising
// edge pulse of the debounced level.
// Revision: 1.0
// ============================================================================
module sr_debounce
   import sr_cond_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_raw,
   output logic      o_deb,
   output logic      o_rise
);
   localparam int              C_CW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [C_CW-1:0] C_LAST = C_CW'(DB_CYCLES - 1);

   logic            r_sync1;
   logic            r_sync2;
   logic            r_deb;
   logic            r_rise;
   logic [C_CW-1:0] r_cnt;
   logic            w_toggle;

   assign w_toggle = (r_sync2 != r_deb) && (r_cnt == C_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_rise  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         // Any match restarts the stability run; a completed run also restarts it.
         if ((r_sync2 == r_deb) || w_toggle) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_toggle) begin
            r_deb <= ~r_deb;
         end
         r_rise <= w_toggle & ~r_deb;
      end
   end

   assign o_deb  = r_deb;
   assign o_rise = r_rise;
endmodule
`default_nettype wire

// File: rtl/sr_input_conditioner.sv
`default_nettype none
// ============================================================================
// sr_input_conditioner -- turns bouncy set/clear requests into mutually
// exclusive one-cycle s/r pulses; simultaneous requests are rejected/counted.
// Revision: 1.0
// ============================================================================
module sr_input_conditioner
   import sr_cond_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  wire logic             clk,
   input  wire logic             rst,
   sr_input_conditioner_if.slave bus
);
   logic             w_req_set;
   logic             w_req_clr;
   logic             w_deb_set;
   logic             w_deb_clr;

   state_t           r_state;
   state_t           w_next;
   logic             r_pend_set;
   logic             r_pend_clr;
   logic             r_s;
   logic             r_r;
   logic             r_conf;
   logic [CNT_W-1:0] r_cnt;

   logic             w_want_s;
   logic             w_want_r;
   logic             w_s_nxt;
   logic             w_r_nxt;
   logic             w_conf_nxt;
   logic             w_pend_set_nxt;
   logic             w_pend_clr_nxt;

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_set (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.set_raw),
      .o_deb  (w_deb_set),
      .o_rise (w_req_set)
   );

   sr_debounce #(.DB_CYCLES(DB_CYCLES)) u_deb_clr (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (bus.clr_raw),
      .o_deb  (w_deb_clr),
      .o_rise (w_req_clr)
   );

   always_comb begin
      w_next         = r_state;
      w_s_nxt        = 1'b0;
      w_r_nxt        = 1'b0;
      w_conf_nxt     = 1'b0;
      w_want_s       = w_req_set | r_pend_set;
      w_want_r       = w_req_clr | r_pend_clr;
      w_pend_set_nxt = r_pend_set | w_req_set;
      w_pend_clr_nxt = r_pend_clr | w_req_clr;
      case (r_state)
         ST_IDLE: begin
            // Every IDLE decision consumes whatever was pending.
            w_pend_set_nxt = 1'b0;
            w_pend_clr_nxt = 1'b0;
            if (w_want_s && w_want_r) begin
               w_conf_nxt = 1'b1;
            end else if (w_want_s) begin
               w_next  = ST_PULSE_S;
               w_s_nxt = 1'b1;
            end else if (w_want_r) begin
               w_next  = ST_PULSE_R;
               w_r_nxt = 1'b1;
            end
         end
         ST_PULSE_S: w_next = ST_GAP;
         ST_PULSE_R: w_next = ST_GAP;
         ST_GAP:     w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_pend_set <= 1'b0;
         r_pend_clr <= 1'b0;
         r_s        <= 1'b0;
         r_r        <= 1'b0;
         r_conf     <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_state    <= w_next;
         r_pend_set <= w_pend_set_nxt;
         r_pend_clr <= w_pend_clr_nxt;
         r_s        <= w_s_nxt;
         r_r        <= w_r_nxt;
         r_conf     <= w_conf_nxt;
         if (w_conf_nxt && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign bus.s              = r_s;
   assign bus.r              = r_r;
   assign bus.conflict       = r_conf;
   assign bus.conflict_count = r_cnt;

   logic w_unused;
   assign w_unused = w_deb_set ^ w_deb_clr;
endmodule
`default_nettype wire

// File: tb/tb_sr_input_conditioner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_sr_input_conditioner -- directed stimulus, behavioural reference model
// and per-cycle compare for sr_input_conditioner.
// Revision: 1.0
// ============================================================================
module tb_sr_input_conditioner;
   import sr_cond_pkg::*;

   localparam int DB      = 4;
   localparam int CW      = 8;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sr_input_conditioner_if #(.CNT_W(CW)) bus ();

   sr_input_conditioner #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a level changes once the last DB synchronised samples
   // all disagree with it; a served pulse blocks new decisions for 3 cycles.
   bit hs[$];
   bit hr[$];
   bit m_deb_s, m_deb_r, m_rise_s, m_rise_r, m_pend_s, m_pend_r;
   int m_cyc  = 0;
   int m_free = 0;
   bit e_s, e_r, e_conf;
   int e_cnt;

   function automatic bit window_is(input bit q[$], input bit v);
      for (int i = q.size() - 1 - DB; i <= q.size() - 2; i++) begin
         if (q[i] != v) return 1'b0;
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin : b_model
      bit fs, fr, ws, wr;
      m_cyc++;
      if (rst) begin
         hs.delete();
         hr.delete();
         for (int i = 0; i < DB + 2; i++) begin
            hs.push_back(1'b0);
            hr.push_back(1'b0);
         end
         m_deb_s = 0; m_deb_r = 0; m_rise_s = 0; m_rise_r = 0;
         m_pend_s = 0; m_pend_r = 0; m_free = 0;
         e_s = 0; e_r = 0; e_conf = 0; e_cnt = 0;
      end else begin
         fs = m_rise_s;
         fr = m_rise_r;
         m_rise_s = 0;
         m_rise_r = 0;
         if (window_is(hs, !m_deb_s)) begin
            m_deb_s  = !m_deb_s;
            m_rise_s = m_deb_s;
         end
         if (window_is(hr, !m_deb_r)) begin
            m_deb_r  = !m_deb_r;
            m_rise_r = m_deb_r;
         end
         hs.push_back(bus.set_raw === 1'b1);
         hr.push_back(bus.clr_raw === 1'b1);
         void'(hs.pop_front());
         void'(hr.pop_front());
         e_s = 0; e_r = 0; e_conf = 0;
         if (m_cyc >= m_free) begin
            ws = fs | m_pend_s;
            wr = fr | m_pend_r;
            m_pend_s = 0;
            m_pend_r = 0;
            if (ws && wr) begin
               e_conf = 1;
               if (e_cnt < CNT_MAX) e_cnt++;
            end else if (ws) begin
               e_s    = 1;
               m_free = m_cyc + 3;
            end else if (wr) begin
               e_r    = 1;
               m_free = m_cyc + 3;
            end
         end else begin
            m_pend_s |= fs;
            m_pend_r |= fr;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_s", bus.s, e_s);
         check("cyc_r", bus.r, e_r);
         check("cyc_conflict", bus.conflict, e_conf);
         check("cyc_count", bus.conflict_count, e_cnt);
         check("cyc_s_and_r", bus.s & bus.r, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count_pulses(input int n, output int ns, output int nr, output int nc);
      ns = 0; nr = 0; nc = 0;
      repeat (n) begin
         @(negedge clk);
         ns += int'(bus.s === 1'b1);
         nr += int'(bus.r === 1'b1);
         nc += int'(bus.conflict === 1'b1);
      end
   endtask

   initial begin : b_stim
      int ns, nr, nc;
      bus.set_raw = 1'b0;
      bus.clr_raw = 1'b0;
      rst = 1'b1;
      step(3);
      chk_en = 1'b1;
      check("reset_s", bus.s, 0);
      check("reset_r", bus.r, 0);
      check("reset_conflict", bus.conflict, 0);
      check("reset_count", bus.conflict_count, 0);
      rst = 1'b0;
      step(4);

      // Clean set, then clean clear 20 cycles later
      bus.set_raw = 1'b1;
      step(6);  check("set_edge6", bus.s, 0);
      step(1);  check("set_edge7", bus.s, 1); check("set_r_low", bus.r, 0);
      step(1);  check("set_width", bus.s, 0);
      bus.set_raw = 1'b0;
      step(12);
      bus.clr_raw = 1'b1;
      step(7);  check("clr_edge7", bus.r, 1); check("clr_s_low", bus.s, 0);
      step(1);  check("clr_width", bus.r, 0);
      bus.clr_raw = 1'b0;
      step(12);

      // Bounce: 1,1,0,0 then hold high
      bus.set_raw = 1'b1; step(2);
      bus.set_raw = 1'b0; step(2);
      bus.set_raw = 1'b1;
      count_pulses(6, ns, nr, nc); check("bounce_early", ns, 0);
      step(1);  check("bounce_edge7", bus.s, 1);
      count_pulses(15, ns, nr, nc); check("bounce_single", ns, 0);
      bus.set_raw = 1'b0;
      step(12);

      // Simultaneous
      bus.set_raw = 1'b1; bus.clr_raw = 1'b1;
      count_pulses(6, ns, nr, nc); check("simul_early", ns + nr + nc, 0);
      step(1);  check("simul_conflict", bus.conflict, 1);
      check("simul_count", bus.conflict_count, 1);
      count_pulses(15, ns, nr, nc);
      check("simul_no_s", ns, 0); check("simul_no_r", nr, 0); check("simul_one", nc, 0);
      bus.set_raw = 1'b0; bus.clr_raw = 1'b0;
      step(12);

      // Back-to-back: clear one cycle behind set
      bus.set_raw = 1'b1; step(1);
      bus.clr_raw = 1'b1; step(6);
      check("b2b_s", bus.s, 1);
      step(1);  check("b2b_gap1", {bus.s, bus.r}, 0);
      step(1);  check("b2b_gap2", {bus.s, bus.r}, 0);
      step(1);  check("b2b_r", bus.r, 1);
      bus.set_raw = 1'b0; bus.clr_raw = 1'b0;
      step(12);

      // Saturation: 260 more rejected pairs
      for (int i = 0; i < 260; i++) begin
         bus.set_raw = 1'b1; bus.clr_raw = 1'b1; step(9);
         bus.set_raw = 1'b0; bus.clr_raw = 1'b0; step(9);
      end
      check("sat_count", bus.conflict_count, 255);

      // Reset while a pulse is out and a clear is landing
      bus.set_raw = 1'b1; step(1);
      bus.clr_raw = 1'b1; step(6);
      check("rst_pre_s", bus.s, 1);
      rst = 1'b1; bus.clr_raw = 1'b0;
      step(1);
      check("rst_s", bus.s, 0); check("rst_r", bus.r, 0);
      check("rst_conflict", bus.conflict, 0); check("rst_count", bus.conflict_count, 0);
      rst = 1'b0;
      count_pulses(6, ns, nr, nc); check("rst_quiet", ns + nr + nc, 0);
      step(1);  check("rst_release_s", bus.s, 1);
      count_pulses(20, ns, nr, nc); check("rst_no_r", nr, 0); check("rst_no_s2", ns, 0);
      bus.set_raw = 1'b0;
      step(10);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
